// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared types, widths and helpers for the reset sequencer
// Purpose: state encoding visible on the debug port, fixed output widths, and
//          the counter width helper used to size each cycle counter.
// Ports:   none (package).
package rst_seq_pkg;

    localparam int STATE_W    = 2;
    localparam int LOSS_CNT_W = 8;

    typedef enum logic [STATE_W-1:0] {
        WAIT_LOCK = 2'd0,
        RELEASE   = 2'd1,
        RUN       = 2'd2
    } state_e;

    // One extra bit so a counter can hold the cycle count itself, not just count-1.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Purpose: counts enabled cycles up to LIMIT and holds there; clear wins over enable.
// Ports:   clk_i      clock
//          rst_i      synchronous active-high reset (count -> 0)
//          clear_i    synchronous clear (count -> 0)
//          enable_i   count one step when not saturated
//          count_o    current count
//          at_limit_o count_o == LIMIT
module sat_counter #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic [WIDTH-1:0] count_o,
    output logic             at_limit_o
);

    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LIM)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o    = cnt_q;
    assign at_limit_o = (cnt_q == LIM);

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release driven by clock-generator lock
// Purpose: holds all stages in reset until lock is stable, releases them one by
//          one with a fixed gap, and re-asserts everything on lock loss or a
//          software re-sequence request.
// Ports:   clk_in        clock
//          reset_in      synchronous active-high reset
//          locked_in     lock flag (already synchronous to clk_in)
//          sw_reset_req  single-cycle re-sequence request
//          rst_out       per-stage active-high resets, bit 0 released first
//          all_ready     every stage released and final gap elapsed
//          lock_fault    sticky: no lock within LOCK_TIMEOUT_CYCLES
//          state_out     debug state (WAIT_LOCK=0, RELEASE=1, RUN=2)
//          lock_loss_cnt lock-loss aborts, saturating (only with RST_SEQ_STATS_EN)
// Build option: define RST_SEQ_STATS_EN to add the lock_loss_cnt port and counter.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES          = 3,
    parameter int LOCK_STABLE_CYCLES  = 16,
    parameter int STAGE_GAP_CYCLES    = 8,
    parameter int LOCK_TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  locked_in,
    input  logic                  sw_reset_req,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  all_ready,
    output logic                  lock_fault,
    output logic [STATE_W-1:0]    state_out
`ifdef RST_SEQ_STATS_EN
    ,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
`endif
);

    localparam int STB_W = cnt_width(LOCK_STABLE_CYCLES);
    localparam int GAP_W = cnt_width(STAGE_GAP_CYCLES);
    localparam int TMO_W = cnt_width(LOCK_TIMEOUT_CYCLES);
    localparam int IDX_W = cnt_width(NUM_STAGES);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [NUM_STAGES-1:0]   rst_q, rst_d;
    logic                    ready_q, ready_d;
    logic                    fault_q, fault_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    logic                    stb_clr, gap_clr, gap_en, tmo_clr, tmo_en;
    logic [STB_W-1:0]        stb_cnt;
    logic [GAP_W-1:0]        gap_cnt;
    logic [TMO_W-1:0]        tmo_cnt;
    logic                    stb_done, gap_wrap, tmo_sat;
    logic                    unused_cnt_bits;

    // Stable counter saturates at LOCK_STABLE_CYCLES-1: reaching it with lock
    // still present at this edge is exactly the release condition.
    sat_counter #(.WIDTH(STB_W), .LIMIT(LOCK_STABLE_CYCLES - 1)) u_stable (
        .clk_i      (clk_in),
        .rst_i      (reset_in),
        .clear_i    (stb_clr),
        .enable_i   (locked_in),
        .count_o    (stb_cnt),
        .at_limit_o (stb_done)
    );

    sat_counter #(.WIDTH(GAP_W), .LIMIT(STAGE_GAP_CYCLES - 1)) u_gap (
        .clk_i      (clk_in),
        .rst_i      (reset_in),
        .clear_i    (gap_clr),
        .enable_i   (gap_en),
        .count_o    (gap_cnt),
        .at_limit_o (gap_wrap)
    );

    sat_counter #(.WIDTH(TMO_W), .LIMIT(LOCK_TIMEOUT_CYCLES)) u_timeout (
        .clk_i      (clk_in),
        .rst_i      (reset_in),
        .clear_i    (tmo_clr),
        .enable_i   (tmo_en),
        .count_o    (tmo_cnt),
        .at_limit_o (tmo_sat)
    );

    assign unused_cnt_bits = ^{stb_cnt, gap_cnt};

    always_comb begin
        state_d = state_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        fault_d = fault_q;
        idx_d   = idx_q;
        stb_clr = 1'b1;
        gap_clr = 1'b1;
        gap_en  = 1'b0;
        tmo_clr = 1'b0;
        tmo_en  = 1'b0;

        case (state_q)
            WAIT_LOCK: begin
                tmo_en  = 1'b1;
                // Raise the fault on the edge the timeout count reaches its limit.
                if (tmo_sat || (tmo_cnt == TMO_LAST)) begin
                    fault_d = 1'b1;
                end
                stb_clr = !locked_in || sw_reset_req;
                if (locked_in && !sw_reset_req && stb_done) begin
                    state_d = RELEASE;
                    rst_d   = rst_q << 1;
                    idx_d   = '0;
                    stb_clr = 1'b1;
                end
            end
            RELEASE: begin
                gap_clr = 1'b0;
                gap_en  = 1'b1;
                if (gap_wrap) begin
                    gap_clr = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end else begin
                        // Shifting zeros in from bit 0 keeps release strictly in order.
                        rst_d = rst_q << 1;
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            RUN: begin
            end
            default: begin
                state_d = WAIT_LOCK;
                rst_d   = '1;
                ready_d = 1'b0;
            end
        endcase

        // Abort overrides any release step taken at the same edge.
        if ((state_q != WAIT_LOCK) && (!locked_in || sw_reset_req)) begin
            state_d = WAIT_LOCK;
            rst_d   = '1;
            ready_d = 1'b0;
            idx_d   = '0;
            stb_clr = 1'b1;
            gap_clr = 1'b1;
            gap_en  = 1'b0;
            tmo_clr = 1'b1;
            tmo_en  = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= WAIT_LOCK;
            rst_q   <= '1;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
            idx_q   <= idx_d;
        end
    end

    assign rst_out    = rst_q;
    assign all_ready  = ready_q;
    assign lock_fault = fault_q;
    assign state_out  = state_q;

`ifdef RST_SEQ_STATS_EN
    logic [LOSS_CNT_W-1:0] loss_q;
    logic                  loss_evt;

    // A simultaneous sw request still counts: lock loss is the cause.
    assign loss_evt = (state_q != WAIT_LOCK) && !locked_in;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            loss_q <= '0;
        end else if (loss_evt && (loss_q != '1)) begin
            loss_q <= loss_q + LOSS_CNT_W'(1);
        end
    end

    assign lock_loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - self-checking bench for reset_sequencer
module tb_reset_sequencer;

    localparam int N      = 3;
    localparam int STABLE = 16;
    localparam int GAP    = 8;
    localparam int TMO    = 1024;
    localparam int VW     = N + 4;

    logic         clk_in = 1'b0;
    logic         reset_in = 1'b1;
    logic         locked_in = 1'b0;
    logic         sw_reset_req = 1'b0;
    logic [N-1:0] rst_out;
    logic         all_ready;
    logic         lock_fault;
    logic [1:0]   state_out;
`ifdef RST_SEQ_STATS_EN
    logic [7:0]   lock_loss_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: time since first release determines everything.
    bit m_wait;
    int m_run;
    int m_tmo;
    bit m_fault;
    int m_t;
    int m_loss;

    always #5 clk_in = ~clk_in;

    reset_sequencer #(
        .NUM_STAGES          (N),
        .LOCK_STABLE_CYCLES  (STABLE),
        .STAGE_GAP_CYCLES    (GAP),
        .LOCK_TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .locked_in    (locked_in),
        .sw_reset_req (sw_reset_req),
        .rst_out      (rst_out),
        .all_ready    (all_ready),
        .lock_fault   (lock_fault),
        .state_out    (state_out)
`ifdef RST_SEQ_STATS_EN
        ,
        .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    function automatic logic [VW-1:0] exp_vec();
        logic [N-1:0] r;
        logic         rdy;
        logic [1:0]   st;
        int           rel;
        if (m_wait) begin
            r   = '1;
            rdy = 1'b0;
            st  = 2'd0;
        end else begin
            rdy = (m_t >= N * GAP);
            rel = rdy ? N : (m_t / GAP + 1);
            if (rel > N) rel = N;
            r   = ~N'((1 << rel) - 1);
            st  = rdy ? 2'd2 : 2'd1;
        end
        return {r, rdy, m_fault, st};
    endfunction

    task automatic model_step(input logic lk, input logic sw, input logic rs);
        if (rs) begin
            m_wait = 1; m_run = 0; m_tmo = 0; m_fault = 0; m_t = 0; m_loss = 0;
        end else if (m_wait) begin
            if (m_tmo < TMO) m_tmo++;
            if (m_tmo >= TMO) m_fault = 1;
            if (lk && !sw) begin
                m_run++;
                if (m_run >= STABLE) begin
                    m_wait = 0; m_t = 0; m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end else if (!lk || sw) begin
            m_wait = 1; m_run = 0; m_tmo = 0;
            if (!lk && m_loss < 255) m_loss++;
        end else if (m_t < N * GAP) begin
            m_t++;
        end
    endtask

    // One clock edge with the given inputs; outputs settle and are sampled 1ns later.
    task automatic tick(input logic lk, input logic sw, input logic rs);
        locked_in    = lk;
        sw_reset_req = sw;
        reset_in     = rs;
        @(posedge clk_in);
        model_step(lk, sw, rs);
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({rst_out, all_ready, lock_fault, state_out} !== {3'b111, 1'b0, 1'b0, 2'd0}) begin
            n_bad++;
            $display("FAIL reset_state: got %b required %b",
                     {rst_out, all_ready, lock_fault, state_out}, {3'b111, 1'b0, 1'b0, 2'd0});
        end
    endtask

    task automatic test_power_up();
        logic [N-1:0] want;
        do_reset();
        for (int e = 1; e <= 45; e++) begin
            tick(1'b1, 1'b0, 1'b0);
            n_cmp++;
            if ({rst_out, all_ready, lock_fault, state_out} !== exp_vec()) begin
                n_bad++;
                $display("FAIL power_up edge %0d: got %b required %b", e,
                         {rst_out, all_ready, lock_fault, state_out}, exp_vec());
            end
            if (e == 15 || e == 16 || e == 24 || e == 32) begin
                want = (e == 15) ? 3'b111 : (e == 16) ? 3'b110 : (e == 24) ? 3'b100 : 3'b000;
                n_cmp++;
                if (rst_out !== want) begin
                    n_bad++;
                    $display("FAIL power_up_rst edge %0d: got %b required %b", e, rst_out, want);
                end
            end
            if (e == 39 || e == 40) begin
                n_cmp++;
                if (all_ready !== (e == 40)) begin
                    n_bad++;
                    $display("FAIL power_up_ready edge %0d: got %b required %b", e, all_ready, (e == 40));
                end
            end
        end
    endtask

    task automatic test_glitch();
        int rel_edge;
        logic lk;
        rel_edge = 0;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            lk = (e != 11);
            tick(lk, 1'b0, 1'b0);
            if (rel_edge == 0 && rst_out !== 3'b111) rel_edge = e;
            n_cmp++;
            if ({rst_out, all_ready, lock_fault, state_out} !== exp_vec()) begin
                n_bad++;
                $display("FAIL glitch edge %0d: got %b required %b", e,
                         {rst_out, all_ready, lock_fault, state_out}, exp_vec());
            end
        end
        n_cmp++;
        if (rel_edge != 27) begin
            n_bad++;
            $display("FAIL glitch_first_release: got edge %0d required edge 27", rel_edge);
        end
    endtask

    task automatic test_lock_loss();
        do_reset();
        for (int e = 1; e <= 45; e++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({rst_out, all_ready, state_out} !== {3'b111, 1'b0, 2'd0}) begin
            n_bad++;
            $display("FAIL lock_loss_abort: got %b required %b",
                     {rst_out, all_ready, state_out}, {3'b111, 1'b0, 2'd0});
        end
        for (int e = 1; e <= 40; e++) begin
            tick(1'b1, 1'b0, 1'b0);
            n_cmp++;
            if ({rst_out, all_ready, lock_fault, state_out} !== exp_vec()) begin
                n_bad++;
                $display("FAIL lock_loss_reseq edge %0d: got %b required %b", e,
                         {rst_out, all_ready, lock_fault, state_out}, exp_vec());
            end
        end
        n_cmp++;
        if (all_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL lock_loss_ready: got %b required 1", all_ready);
        end
`ifdef RST_SEQ_STATS_EN
        n_cmp++;
        if (lock_loss_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL lock_loss_cnt: got %0d required 1", lock_loss_cnt);
        end
`endif
    endtask

    task automatic test_sw_reset();
        do_reset();
        for (int e = 1; e <= 26; e++) tick(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (rst_out !== 3'b100) begin
            n_bad++;
            $display("FAIL sw_reset_pre: got %b required 100", rst_out);
        end
        tick(1'b1, 1'b1, 1'b0);
        n_cmp++;
        if ({rst_out, all_ready, state_out} !== {3'b111, 1'b0, 2'd0}) begin
            n_bad++;
            $display("FAIL sw_reset_abort: got %b required %b",
                     {rst_out, all_ready, state_out}, {3'b111, 1'b0, 2'd0});
        end
        for (int e = 1; e <= 16; e++) begin
            tick(1'b1, 1'b0, 1'b0);
            n_cmp++;
            if ({rst_out, all_ready, lock_fault, state_out} !== exp_vec()) begin
                n_bad++;
                $display("FAIL sw_reset_reseq edge %0d: got %b required %b", e,
                         {rst_out, all_ready, lock_fault, state_out}, exp_vec());
            end
        end
        n_cmp++;
        if (rst_out !== 3'b110) begin
            n_bad++;
            $display("FAIL sw_reset_release: got %b required 110", rst_out);
        end
`ifdef RST_SEQ_STATS_EN
        n_cmp++;
        if (lock_loss_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL sw_reset_loss_cnt: got %0d required 0", lock_loss_cnt);
        end
`endif
    endtask

    task automatic test_lock_fault();
        do_reset();
        for (int e = 1; e <= 1030; e++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (e == 1023 || e == 1024 || e == 1030) begin
                n_cmp++;
                if (lock_fault !== (e >= 1024)) begin
                    n_bad++;
                    $display("FAIL lock_fault edge %0d: got %b required %b", e, lock_fault, (e >= 1024));
                end
            end
        end
        for (int e = 1; e <= 42; e++) begin
            tick(1'b1, 1'b0, 1'b0);
            n_cmp++;
            if ({rst_out, all_ready, lock_fault, state_out} !== exp_vec()) begin
                n_bad++;
                $display("FAIL lock_fault_late_lock edge %0d: got %b required %b", e,
                         {rst_out, all_ready, lock_fault, state_out}, exp_vec());
            end
        end
        n_cmp++;
        if ({all_ready, lock_fault} !== 2'b11) begin
            n_bad++;
            $display("FAIL lock_fault_sticky: got %b required 11", {all_ready, lock_fault});
        end
        tick(1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (lock_fault !== 1'b0) begin
            n_bad++;
            $display("FAIL lock_fault_clear: got %b required 0", lock_fault);
        end
    endtask

    task automatic test_reset_mid_release();
        do_reset();
        for (int e = 1; e <= 28; e++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        n_cmp++;
        if ({rst_out, all_ready, lock_fault, state_out} !== {3'b111, 1'b0, 1'b0, 2'd0}) begin
            n_bad++;
            $display("FAIL reset_mid_release: got %b required %b",
                     {rst_out, all_ready, lock_fault, state_out}, {3'b111, 1'b0, 1'b0, 2'd0});
        end
    endtask

    task automatic test_random();
        logic lk, sw, rs;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            lk = ($urandom_range(0, 39) != 0);
            sw = ($urandom_range(0, 99) == 0);
            rs = ($urandom_range(0, 299) == 0);
            tick(lk, sw, rs);
            n_cmp++;
            if ({rst_out, all_ready, lock_fault, state_out} !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cycle %0d: got %b required %b", c,
                         {rst_out, all_ready, lock_fault, state_out}, exp_vec());
            end
`ifdef RST_SEQ_STATS_EN
            n_cmp++;
            if (lock_loss_cnt !== 8'(m_loss)) begin
                n_bad++;
                $display("FAIL random_loss_cnt cycle %0d: got %0d required %0d", c, lock_loss_cnt, m_loss);
            end
`endif
        end
    endtask

    initial begin
        m_wait = 1; m_run = 0; m_tmo = 0; m_fault = 0; m_t = 0; m_loss = 0;
        test_reset();
        test_power_up();
        test_glitch();
        test_lock_loss();
        test_sw_reset();
        test_lock_fault();
        test_reset_mid_release();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
